// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM handshake and arbiter state types.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {ARB_IDLE, ARB_IGRANT, ARB_DGRANT} arbstate_t;
endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between fetch and data with data priority and fetch anti-starvation.
// Define MEM_ARB_LLSC_EN to enable LL/SC link tracking; otherwise datomic is ignored.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  logic      datomic,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);
    arbstate_t state, next;
    logic [CNT_W-1:0] starve_cnt;
    logic d_req, force_i, ram_done, d_done, ll_op, sc_op, sc_ok, sc_fail;

`ifdef MEM_ARB_LLSC_EN
    localparam bit LLSC = 1'b1;
    logic  link_valid;
    word_t link_addr;
    assign sc_ok = link_valid && link_addr == daddr;
    always_ff @(posedge CLK) begin
        if (RST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (d_done) begin
            if (ll_op) begin
                link_addr  <= daddr;
                link_valid <= 1'b1;
            end else if (sc_op || (dWEN && daddr == link_addr)) begin
                link_valid <= 1'b0;
            end
        end
    end
`else
    localparam bit LLSC = 1'b0;
    assign sc_ok = 1'b0;
`endif

    assign d_req    = dREN | dWEN;
    assign ll_op    = dREN && datomic;
    assign sc_op    = dWEN && datomic;
    assign sc_fail  = LLSC && sc_op && !sc_ok;
    assign ram_done = ramstate == ACCESS || ramstate == ERROR;
    // At the limit a pending fetch wins one arbitration even against data.
    assign force_i  = iREN && STARVE_LIMIT != 0 && starve_cnt == CNT_W'(STARVE_LIMIT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
        end else begin
            state <= next;
            if (state == ARB_IDLE && next == ARB_DGRANT && iREN && starve_cnt < CNT_W'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;
            else if (state == ARB_IDLE && next == ARB_IGRANT)
                starve_cnt <= '0;
        end
    end

    always_comb begin
        next     = state;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        d_done   = 1'b0;
        unique case (state)
            ARB_IDLE: next = (d_req && !force_i) ? ARB_DGRANT : iREN ? ARB_IGRANT : ARB_IDLE;
            ARB_IGRANT: begin
                if (!iREN) begin
                    next = ARB_IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_done) begin
                        iwait = 1'b0;
                        iload = ramstate == ACCESS ? ramload : '0;
                        next  = ARB_IDLE;
                    end
                end
            end
            ARB_DGRANT: begin
                if (!d_req) begin
                    next = ARB_IDLE;
                end else if (sc_fail) begin
                    dwait  = 1'b0;
                    d_done = 1'b1;
                    next   = ARB_IDLE;
                end else begin
                    ramREN   = dREN;
                    ramWEN   = dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ram_done) begin
                        dwait  = 1'b0;
                        d_done = 1'b1;
                        next   = ARB_IDLE;
                        dload  = dREN ? (ramstate == ACCESS ? ramload : '0)
                                      : {31'b0, LLSC && sc_op && ramstate == ACCESS};
                    end
                end
            end
            default: next = ARB_IDLE;
        endcase
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: table-driven per-cycle vectors plus hand sequences for LL/SC, errors and dropped requests.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    typedef struct {
        logic       rst, iren, dren, dwen, datomic;
        word_t      iaddr, daddr, dstore, ramload;
        logic [1:0] rs;
        logic       e_ren, e_wen;
        word_t      e_addr, e_store;
        logic       e_idone, e_ddone;
        word_t      e_iload, e_dload;
    } vec_t;

    logic      CLK = 1'b0;
    logic      RST, iREN, dREN, dWEN, datomic;
    word_t     iaddr, daddr, dstore, ramload;
    ramstate_t ramstate;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore;
    int        checks = 0;
    int        errors = 0;
    vec_t      tbl[$];

    memory_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input string sig, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", tag, sig, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, check combinational outputs before the rising edge.
    task automatic run(input vec_t v, input string tag);
        @(negedge CLK);
        RST = v.rst; iREN = v.iren; dREN = v.dren; dWEN = v.dwen; datomic = v.datomic;
        iaddr = v.iaddr; daddr = v.daddr; dstore = v.dstore; ramload = v.ramload;
        ramstate = ramstate_t'(v.rs);
        #1;
        chk(tag, "ramREN", 32'(ramREN), 32'(v.e_ren));
        chk(tag, "ramWEN", 32'(ramWEN), 32'(v.e_wen));
        chk(tag, "ramaddr", ramaddr, v.e_addr);
        chk(tag, "ramstore", ramstore, v.e_store);
        chk(tag, "iwait", 32'(iwait), 32'(!v.e_idone));
        chk(tag, "dwait", 32'(dwait), 32'(!v.e_ddone));
        chk(tag, "iload", iload, v.e_iload);
        chk(tag, "dload", dload, v.e_dload);
    endtask

    initial begin
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; datomic = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        @(posedge CLK);

        // reset held with both requests: nothing granted
        repeat (2) tbl.push_back(vec_t'{default: 0, rst: 1, iren: 1, dren: 1, rs: ACCESS});
        // fetch with two BUSY cycles
        tbl.push_back(vec_t'{default: 0, iren: 1, iaddr: 32'h40});
        repeat (2) tbl.push_back(vec_t'{default: 0, iren: 1, iaddr: 32'h40, rs: BUSY,
                                        e_ren: 1, e_addr: 32'h40});
        tbl.push_back(vec_t'{default: 0, iren: 1, iaddr: 32'h40, rs: ACCESS, ramload: 32'hDEADBEEF,
                             e_ren: 1, e_addr: 32'h40, e_idone: 1, e_iload: 32'hDEADBEEF});
        tbl.push_back(vec_t'{default: 0});
        // simultaneous fetch and write: data first, bubble, then fetch
        tbl.push_back(vec_t'{default: 0, iren: 1, iaddr: 32'h44, dwen: 1, daddr: 32'h80, dstore: 32'h1234});
        tbl.push_back(vec_t'{default: 0, iren: 1, iaddr: 32'h44, dwen: 1, daddr: 32'h80, dstore: 32'h1234,
                             rs: ACCESS, e_wen: 1, e_addr: 32'h80, e_store: 32'h1234, e_ddone: 1});
        tbl.push_back(vec_t'{default: 0, iren: 1, iaddr: 32'h44, rs: ACCESS});
        tbl.push_back(vec_t'{default: 0, iren: 1, iaddr: 32'h44, rs: ACCESS, ramload: 32'hCAFE0001,
                             e_ren: 1, e_addr: 32'h44, e_idone: 1, e_iload: 32'hCAFE0001});
        tbl.push_back(vec_t'{default: 0});
        // starvation: four data grants, one forced fetch, then data again
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(vec_t'{default: 0, iren: 1, iaddr: 32'h48, dren: 1, daddr: 32'h200,
                                 rs: ACCESS, ramload: 32'h11110000});
            if (i == 4)
                tbl.push_back(vec_t'{default: 0, iren: 1, iaddr: 32'h48, dren: 1, daddr: 32'h200,
                                     rs: ACCESS, ramload: 32'h11110000, e_ren: 1, e_addr: 32'h48,
                                     e_idone: 1, e_iload: 32'h11110000});
            else
                tbl.push_back(vec_t'{default: 0, iren: 1, iaddr: 32'h48, dren: 1, daddr: 32'h200,
                                     rs: ACCESS, ramload: 32'h11110000, e_ren: 1, e_addr: 32'h200,
                                     e_ddone: 1, e_dload: 32'h11110000});
        end
        tbl.push_back(vec_t'{default: 0});

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // RAM error completes the fetch with a zero word
        run(vec_t'{default: 0, iren: 1, iaddr: 32'h60, ramload: 32'h99}, "err_idle");
        run(vec_t'{default: 0, iren: 1, iaddr: 32'h60, ramload: 32'h99, rs: ERROR,
                   e_ren: 1, e_addr: 32'h60, e_idone: 1}, "err_grant");
        run(vec_t'{default: 0}, "err_after");

`ifdef MEM_ARB_LLSC_EN
        // LL then successful SC, then failing SC with no RAM write
        run(vec_t'{default: 0, dren: 1, datomic: 1, daddr: 32'h100}, "ll_idle");
        run(vec_t'{default: 0, dren: 1, datomic: 1, daddr: 32'h100, rs: ACCESS, ramload: 32'h55,
                   e_ren: 1, e_addr: 32'h100, e_ddone: 1, e_dload: 32'h55}, "ll");
        run(vec_t'{default: 0}, "ll_after");
        run(vec_t'{default: 0, dwen: 1, datomic: 1, daddr: 32'h100, dstore: 7}, "sc1_idle");
        run(vec_t'{default: 0, dwen: 1, datomic: 1, daddr: 32'h100, dstore: 7, rs: ACCESS,
                   e_wen: 1, e_addr: 32'h100, e_store: 7, e_ddone: 1, e_dload: 1}, "sc1");
        run(vec_t'{default: 0}, "sc1_after");
        run(vec_t'{default: 0, dwen: 1, datomic: 1, daddr: 32'h100, dstore: 7}, "sc2_idle");
        run(vec_t'{default: 0, dwen: 1, datomic: 1, daddr: 32'h100, dstore: 7, rs: ACCESS,
                   e_ddone: 1}, "sc2_fail");
        run(vec_t'{default: 0}, "sc2_after");
        // plain write to the linked address breaks the link
        run(vec_t'{default: 0, dren: 1, datomic: 1, daddr: 32'h100}, "ll2_idle");
        run(vec_t'{default: 0, dren: 1, datomic: 1, daddr: 32'h100, rs: ACCESS, ramload: 32'h66,
                   e_ren: 1, e_addr: 32'h100, e_ddone: 1, e_dload: 32'h66}, "ll2");
        run(vec_t'{default: 0, dwen: 1, daddr: 32'h100, dstore: 9}, "wr_idle");
        run(vec_t'{default: 0, dwen: 1, daddr: 32'h100, dstore: 9, rs: ACCESS,
                   e_wen: 1, e_addr: 32'h100, e_store: 9, e_ddone: 1}, "wr");
        run(vec_t'{default: 0, dwen: 1, datomic: 1, daddr: 32'h100, dstore: 7}, "sc3_idle");
        run(vec_t'{default: 0, dwen: 1, datomic: 1, daddr: 32'h100, dstore: 7, rs: ACCESS,
                   e_ddone: 1}, "sc3_fail");
        run(vec_t'{default: 0}, "sc3_after");
`else
        // datomic ignored: SC is a plain write, LL a plain read
        run(vec_t'{default: 0, dwen: 1, datomic: 1, daddr: 32'h100, dstore: 7}, "sc_idle");
        run(vec_t'{default: 0, dwen: 1, datomic: 1, daddr: 32'h100, dstore: 7, rs: ACCESS,
                   e_wen: 1, e_addr: 32'h100, e_store: 7, e_ddone: 1}, "sc_plain");
        run(vec_t'{default: 0}, "sc_after");
        run(vec_t'{default: 0, dren: 1, datomic: 1, daddr: 32'h104}, "ll_idle");
        run(vec_t'{default: 0, dren: 1, datomic: 1, daddr: 32'h104, rs: ACCESS, ramload: 32'h77,
                   e_ren: 1, e_addr: 32'h104, e_ddone: 1, e_dload: 32'h77}, "ll_plain");
        run(vec_t'{default: 0}, "ll_after");
`endif

        // data request dropped while BUSY: strobe falls at once, arbiter returns to IDLE
        run(vec_t'{default: 0, dren: 1, daddr: 32'h300}, "drop_idle");
        run(vec_t'{default: 0, dren: 1, daddr: 32'h300, rs: BUSY, e_ren: 1, e_addr: 32'h300}, "drop_busy");
        run(vec_t'{default: 0, rs: BUSY}, "drop");
        run(vec_t'{default: 0, iren: 1, iaddr: 32'h70}, "drop_idle2");
        run(vec_t'{default: 0, iren: 1, iaddr: 32'h70, rs: ACCESS, ramload: 32'hABCD,
                   e_ren: 1, e_addr: 32'h70, e_idone: 1, e_iload: 32'hABCD}, "drop_fetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
